wr_control_p: RTL and testbench

- Parametrised configuration-write sequencer for the UART configuration path.
- Counts received bytes (`rxrdy` pulses) within a frame and pulses `shift_rxregs` once per byte to advance the receive shift registers.
- After `NUM_BYTES` bytes it pulses `load_confregs`/`done_wr` to commit the configuration registers.
- Adds behaviour the previous controller lacks: configurable frame length, an inter-byte timeout, an external abort, an error flag, a byte-count output and a busy flag.

---
 rtl/wr_control_p.sv | 139 +++++++++++++
 tb/tb_wr_control_p.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_control_p.sv
// Configuration-write sequencer: counts received bytes in a frame, pulses a shift per byte
// and a commit once the frame is complete, with inter-byte timeout and external abort.
module wr_control_p #(
  parameter int NUM_BYTES = 10,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 1000,
  parameter int TO_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxrdy,
  input  logic             start_wr,
  input  logic             abort,
  output logic             shift_rxregs,
  output logic             load_confregs,
  output logic             done_wr,
  output logic             err_wr,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic [2:0]       wr_leds
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_SHIFT = 3'b001,
    S_LOAD  = 3'b010,
    S_WAIT  = 3'b011,
    S_ERR   = 3'b100
  } state_e;

  // Comparing the pre-increment count avoids a CNT_W+1 bit adder in the exit test.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (rxrdy && start_wr) begin
          state_d = S_SHIFT;
          err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_LOAD;
        end else if (abort) begin
          state_d = S_ERR;
        end else if (rxrdy) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        // abort outranks a byte, and a byte outranks a coincident timeout
        if (abort) begin
          state_d = S_ERR;
        end else if (rxrdy) begin
          state_d = S_SHIFT;
        end else if (timer_q == LAST_TO) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    shift_rxregs  = 1'b0;
    load_confregs = 1'b0;
    done_wr       = 1'b0;
    busy          = 1'b1;
    wr_leds       = 3'b111;
    case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        wr_leds = 3'b001;
      end
      S_SHIFT: begin
        shift_rxregs = 1'b1;
        wr_leds      = 3'b010;
      end
      S_LOAD: begin
        load_confregs = 1'b1;
        done_wr       = 1'b1;
        wr_leds       = 3'b011;
      end
      S_WAIT:  wr_leds = 3'b100;
      S_ERR:   wr_leds = 3'b101;
      default: wr_leds = 3'b111;
    endcase
  end

  assign byte_cnt = cnt_q;
  assign err_wr   = err_q;

endmodule

// File: tb/tb_wr_control_p.sv
// Randomised bench for wr_control_p: three parameterisations share one stimulus stream,
// a frame-level reference model predicts each cycle's outputs into per-instance scoreboards.
module tb_wr_control_p;

  localparam int N0 = 10, T0 = 20;
  localparam int N1 = 2,  T1 = 20;
  localparam int N2 = 15, T2 = 5;

  logic clk = 1'b0;
  logic rst, rxrdy, start_wr, abort;

  always #5 clk = ~clk;

  logic       sh0, ld0, dn0, er0, bz0;
  logic [3:0] cn0;
  logic [2:0] le0;
  logic       sh1, ld1, dn1, er1, bz1;
  logic [1:0] cn1;
  logic [2:0] le1;
  logic       sh2, ld2, dn2, er2, bz2;
  logic [3:0] cn2;
  logic [2:0] le2;

  wr_control_p #(.NUM_BYTES(N0), .CNT_W(4), .TIMEOUT(T0), .TO_W(5)) dut0 (
    .clk(clk), .rst(rst), .rxrdy(rxrdy), .start_wr(start_wr), .abort(abort),
    .shift_rxregs(sh0), .load_confregs(ld0), .done_wr(dn0), .err_wr(er0),
    .byte_cnt(cn0), .busy(bz0), .wr_leds(le0));

  wr_control_p #(.NUM_BYTES(N1), .CNT_W(2), .TIMEOUT(T1), .TO_W(5)) dut1 (
    .clk(clk), .rst(rst), .rxrdy(rxrdy), .start_wr(start_wr), .abort(abort),
    .shift_rxregs(sh1), .load_confregs(ld1), .done_wr(dn1), .err_wr(er1),
    .byte_cnt(cn1), .busy(bz1), .wr_leds(le1));

  wr_control_p #(.NUM_BYTES(N2), .CNT_W(4), .TIMEOUT(T2), .TO_W(3)) dut2 (
    .clk(clk), .rst(rst), .rxrdy(rxrdy), .start_wr(start_wr), .abort(abort),
    .shift_rxregs(sh2), .load_confregs(ld2), .done_wr(dn2), .err_wr(er2),
    .byte_cnt(cn2), .busy(bz2), .wr_leds(le2));

  typedef struct packed {
    logic       shift;
    logic       load;
    logic       done;
    logic       err;
    logic [3:0] cnt;
    logic       busy;
    logic [2:0] leds;
  } obs_t;

  // Frame-level view: which one-cycle event is showing, whether we are waiting for a byte,
  // bytes already taken in this frame, and quiet cycles spent waiting.
  typedef struct {
    bit shifting;
    bit loading;
    bit failing;
    bit waiting;
    bit err;
    int bytes;
    int quiet;
  } mdl_t;

  mdl_t m[3];
  int   nb[3] = '{N0, N1, N2};
  int   tmo[3] = '{T0, T1, T2};

  obs_t q0[$], q1[$], q2[$];
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t predict(input mdl_t s);
    obs_t o;
    o.shift = s.shifting;
    o.load  = s.loading;
    o.done  = s.loading;
    o.err   = s.err;
    o.cnt   = 4'(s.bytes);
    o.busy  = s.shifting | s.loading | s.failing | s.waiting;
    if (s.shifting)     o.leds = 3'b010;
    else if (s.loading) o.leds = 3'b011;
    else if (s.waiting) o.leds = 3'b100;
    else if (s.failing) o.leds = 3'b101;
    else                o.leds = 3'b001;
    return o;
  endfunction

  function automatic mdl_t step(input mdl_t s, input int n, input int t,
                                input bit r, input bit rx, input bit st, input bit ab);
    mdl_t x = s;
    if (r) begin
      x = '{default: 0};
    end else if (s.loading) begin
      x.loading = 0;
      x.bytes   = 0;
    end else if (s.failing) begin
      x.failing = 0;
      x.err     = 1;
      x.bytes   = 0;
    end else if (s.shifting) begin
      x.shifting = 0;
      x.bytes    = s.bytes + 1;
      if (x.bytes == n)  x.loading = 1;
      else if (ab)       x.failing = 1;
      else if (rx)       x.shifting = 1;
      else begin
        x.waiting = 1;
        x.quiet   = 0;
      end
    end else if (s.waiting) begin
      if (ab) begin
        x.waiting = 0;
        x.failing = 1;
      end else if (rx) begin
        x.waiting  = 0;
        x.shifting = 1;
      end else if (s.quiet == t - 1) begin
        x.waiting = 0;
        x.failing = 1;
      end else begin
        x.quiet = s.quiet + 1;
      end
    end else if (rx && st) begin
      x.shifting = 1;
      x.err      = 0;
    end
    return x;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual shift=%b load=%b done=%b err=%b cnt=%0d busy=%b leds=%b required shift=%b load=%b done=%b err=%b cnt=%0d busy=%b leds=%b",
               name, $time, act.shift, act.load, act.done, act.err, act.cnt, act.busy, act.leds,
               exp.shift, exp.load, exp.done, exp.err, exp.cnt, exp.busy, exp.leds);
    end
  endtask

  task automatic cyc(input bit r, input bit rx, input bit st, input bit ab);
    obs_t e0, e1, e2;
    rst = r; rxrdy = rx; start_wr = st; abort = ab;
    for (int i = 0; i < 3; i++) m[i] = step(m[i], nb[i], tmo[i], r, rx, st, ab);
    e0 = predict(m[0]);
    e1 = predict(m[1]);
    e2 = predict(m[2]);
    @(posedge clk);
    #1;
    q0.push_back(e0);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("n10", {sh0, ld0, dn0, er0, cn0, bz0, le0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("n2", {sh1, ld1, dn1, er1, {2'b00, cn1}, bz1, le1}, e);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("n15", {sh2, ld2, dn2, er2, cn2, bz2, le2}, e);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dens;
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    rst = 1'b1; rxrdy = 1'b0; start_wr = 1'b0; abort = 1'b0;
    repeat (3) cyc(1, 0, 1, 0);

    // rxrdy without start_wr, then abort while idle
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    idle(2);

    // nominal frame with bytes 16 cycles apart
    for (int b = 0; b < 10; b++) begin
      cyc(0, 1, 1, 0);
      idle(15);
    end
    idle(4);

    // back-to-back bytes, with extra bytes landing on the final shift and on the load
    for (int b = 0; b < 12; b++) cyc(0, 1, 1, 0);
    idle(4);

    // three bytes then silence until timeout
    for (int b = 0; b < 3; b++) cyc(0, 1, 1, 0);
    idle(26);

    // byte arrives on the last waiting cycle before timeout
    for (int b = 0; b < 3; b++) cyc(0, 1, 1, 0);
    idle(20);
    cyc(0, 1, 1, 0);
    idle(2);
    cyc(0, 0, 1, 1);
    idle(3);

    // five bytes, then abort and rxrdy together while waiting
    for (int b = 0; b < 5; b++) begin
      cyc(0, 1, 1, 0);
      idle(2);
    end
    cyc(0, 1, 1, 1);
    idle(3);

    // reset in the middle of a frame, then a full frame
    for (int b = 0; b < 7; b++) begin
      cyc(0, 1, 1, 0);
      idle(1);
    end
    cyc(1, 0, 1, 0);
    for (int b = 0; b < 10; b++) begin
      cyc(0, 1, 1, 0);
      idle(2);
    end
    idle(5);

    // random traffic with a byte density that changes every block
    for (int blk = 0; blk < 15; blk++) begin
      dens = $urandom_range(3, 100);
      for (int c = 0; c < 200; c++) begin
        cyc($urandom_range(0, 399) == 0,
            $urandom_range(1, 100) <= dens,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 49) == 0);
      end
    end
    idle(3);

    @(negedge clk);
    #1;
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending required=0 pending", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
